// File: rtl/icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : icache_fill_ctrl
// Purpose  : Instruction-cache line-fill controller. On a hit it refreshes
//            the replacement policy's MRU state for the accessed index. On a
//            miss it latches the line base and the victim way, reads the line
//            word by word from memory into the data array, writes the tag on
//            the final word, and then spends one cycle marking the victim MRU.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   lookup_valid/addr          cache access presented this cycle
//   hit_vector                 per-way tag match for lookup_addr
//   icache_replacement_select  victim way proposed by the replacement policy
//   icache_replacement_update  MRU write strobe (with mru_vector, index)
//   mem_read/mem_address       memory read request, held until mem_resp
//   mem_resp/mem_rdata         one-cycle read data strobe and data
//   way_write/index/offset/wdata  data-array write
//   tag_write                  tag/valid write for the filled line
//   busy, fill_done            fill in progress, completion pulse
// ============================================================================
module icache_fill_ctrl #(
    parameter int num_sets       = 4,
    parameter int lines_per_set  = 16,
    parameter int words_per_line = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                lookup_valid,
    input  logic [31:0]                         lookup_addr,
    input  logic [num_sets-1:0]                 hit_vector,
    input  logic [num_sets-1:0]                 icache_replacement_select,
    output logic                                icache_replacement_update,
    output logic [num_sets-1:0]                 mru_vector,
    output logic [$clog2(lines_per_set)-1:0]    index,
    output logic                                mem_read,
    output logic [31:0]                         mem_address,
    input  logic                                mem_resp,
    input  logic [31:0]                         mem_rdata,
    output logic [num_sets-1:0]                 way_write,
    output logic [$clog2(lines_per_set)-1:0]    way_index,
    output logic [$clog2(words_per_line)-1:0]   way_offset,
    output logic [31:0]                         way_wdata,
    output logic                                tag_write,
    output logic                                busy,
    output logic                                fill_done
);

    localparam int IW = $clog2(lines_per_set);
    localparam int OW = $clog2(words_per_line);
    localparam int LW = 30 - OW;    // line-base width: addr[31:2+OW]

    localparam logic [OW-1:0] c_last_beat = OW'(words_per_line - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t              state_q;
    logic [OW-1:0]       beat_q;
    logic [LW-1:0]       line_q;
    logic [num_sets-1:0] victim_q;

    logic [num_sets-1:0] victim_d;
    logic [IW-1:0]       w_lookup_index;
    logic [IW-1:0]       w_fill_index;
    logic                w_miss;
    logic                w_unused;

    assign w_lookup_index = lookup_addr[2+OW+IW-1 : 2+OW];
    assign w_fill_index   = line_q[IW-1:0];
    assign w_miss         = lookup_valid && (hit_vector == '0);
    assign w_unused       = ^lookup_addr[1:0];

    // Lowest set bit of the select wins; an all-zero select falls back to way 0.
    always_comb begin
        victim_d = num_sets'(1);
        for (int i = num_sets - 1; i >= 0; i--) begin
            if (icache_replacement_select[i]) begin
                victim_d    = '0;
                victim_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            line_q   <= '0;
            victim_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_miss) begin
                        state_q  <= S_FETCH;
                        beat_q   <= '0;
                        line_q   <= lookup_addr[31:2+OW];
                        victim_q <= victim_d;
                    end
                end
                S_FETCH: begin
                    if (mem_resp) begin
                        // Wraps to zero naturally after the last beat.
                        beat_q <= beat_q + OW'(1);
                        if (beat_q == c_last_beat) begin
                            state_q <= S_UPDATE;
                        end
                    end
                end
                S_UPDATE: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // All outputs are decoded from the current state and inputs so that hit
    // updates and data writes land in the same cycle as their trigger. The
    // rst term keeps the outputs quiet even while a lookup is presented.
    always_comb begin
        icache_replacement_update = 1'b0;
        mru_vector                = '0;
        index                     = '0;
        mem_read                  = 1'b0;
        mem_address               = '0;
        way_write                 = '0;
        way_index                 = '0;
        way_offset                = '0;
        way_wdata                 = '0;
        tag_write                 = 1'b0;
        busy                      = 1'b0;
        fill_done                 = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (lookup_valid && (hit_vector != '0)) begin
                        icache_replacement_update = 1'b1;
                        mru_vector                = hit_vector;
                        index                     = w_lookup_index;
                    end
                end
                S_FETCH: begin
                    mem_read    = 1'b1;
                    busy        = 1'b1;
                    mem_address = {line_q, beat_q, 2'b00};
                    if (mem_resp) begin
                        way_write  = victim_q;
                        way_index  = w_fill_index;
                        way_offset = beat_q;
                        way_wdata  = mem_rdata;
                        tag_write  = (beat_q == c_last_beat);
                    end
                end
                S_UPDATE: begin
                    icache_replacement_update = 1'b1;
                    mru_vector                = victim_q;
                    index                     = w_fill_index;
                    fill_done                 = 1'b1;
                    busy                      = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_fill_ctrl
// Purpose  : Directed self-checking bench for icache_fill_ctrl (default
//            parameters: 4 ways, 16 lines, 4 words per line).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_icache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_addr = '0;
    logic [3:0]  hit_vector = '0;
    logic [3:0]  sel = '0;
    logic        upd;
    logic [3:0]  mru_vector;
    logic [3:0]  index;
    logic        mem_read;
    logic [31:0] mem_address;
    logic        mem_resp = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  way_write;
    logic [3:0]  way_index;
    logic [1:0]  way_offset;
    logic [31:0] way_wdata;
    logic        tag_write;
    logic        busy;
    logic        fill_done;

    int n_tests = 0;
    int n_fail  = 0;

    icache_fill_ctrl dut (
        .clk                       (clk),
        .rst                       (rst),
        .lookup_valid              (lookup_valid),
        .lookup_addr               (lookup_addr),
        .hit_vector                (hit_vector),
        .icache_replacement_select (sel),
        .icache_replacement_update (upd),
        .mru_vector                (mru_vector),
        .index                     (index),
        .mem_read                  (mem_read),
        .mem_address               (mem_address),
        .mem_resp                  (mem_resp),
        .mem_rdata                 (mem_rdata),
        .way_write                 (way_write),
        .way_index                 (way_index),
        .way_offset                (way_offset),
        .way_wdata                 (way_wdata),
        .tag_write                 (tag_write),
        .busy                      (busy),
        .fill_done                 (fill_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a miss, enter FETCH, and stream every beat with one response per cycle.
    task automatic quick_fill(input logic [31:0] addr, input logic [3:0] s,
                              input logic [3:0] exp_victim, input logic [3:0] exp_idx);
        lookup_valid = 1'b1; lookup_addr = addr; hit_vector = 4'b0000; sel = s;
        #1;
        check_eq("miss_no_update", {63'd0, upd}, 64'd0);
        tick();
        lookup_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_resp = 1'b1; mem_rdata = 32'hA000_0000 + addr + b;
            if (b == 2) sel = ~s;     // select changes mid-fill
            #1;
            check_eq("fill_mem_read",  {63'd0, mem_read}, 64'd1);
            check_eq("fill_mem_addr",  {32'd0, mem_address}, {32'd0, addr + 32'(4*b)});
            check_eq("fill_way_write", {60'd0, way_write}, {60'd0, exp_victim});
            check_eq("fill_way_index", {60'd0, way_index}, {60'd0, exp_idx});
            check_eq("fill_offset",    {62'd0, way_offset}, 64'(b));
            check_eq("fill_wdata",     {32'd0, way_wdata}, {32'd0, 32'hA000_0000 + addr + b});
            check_eq("fill_tag_write", {63'd0, tag_write}, (b == 3) ? 64'd1 : 64'd0);
            tick();
        end
        mem_resp = 1'b0;
        #1;
        check_eq("upd_update",   {63'd0, upd}, 64'd1);
        check_eq("upd_mru",      {60'd0, mru_vector}, {60'd0, exp_victim});
        check_eq("upd_index",    {60'd0, index}, {60'd0, exp_idx});
        check_eq("upd_done",     {63'd0, fill_done}, 64'd1);
        check_eq("upd_mem_read", {63'd0, mem_read}, 64'd0);
        tick();
        check_eq("idle_busy",    {63'd0, busy}, 64'd0);
        check_eq("idle_done",    {63'd0, fill_done}, 64'd0);
    endtask

    initial begin
        int resps;
        int beat;

        // Reset state, including a lookup presented during reset.
        lookup_valid = 1'b1; lookup_addr = 32'h40; hit_vector = 4'b0100;
        #2;
        check_eq("rst_update",   {63'd0, upd}, 64'd0);
        check_eq("rst_mem_read", {63'd0, mem_read}, 64'd0);
        check_eq("rst_busy",     {63'd0, busy}, 64'd0);
        check_eq("rst_mru",      {60'd0, mru_vector}, 64'd0);
        tick();
        rst = 1'b0; lookup_valid = 1'b0; hit_vector = '0;
        tick();

        // Hit: same-cycle MRU update.
        lookup_valid = 1'b1; lookup_addr = 32'h0000_0040; hit_vector = 4'b0100;
        #1;
        check_eq("hit_update", {63'd0, upd}, 64'd1);
        check_eq("hit_mru",    {60'd0, mru_vector}, 64'h4);
        check_eq("hit_index",  {60'd0, index}, 64'd4);
        check_eq("hit_busy",   {63'd0, busy}, 64'd0);
        check_eq("hit_ww",     {60'd0, way_write}, 64'd0);
        tick();
        lookup_valid = 1'b0; hit_vector = '0;
        #1;
        check_eq("nohit_mru",  {60'd0, mru_vector}, 64'd0);
        tick();

        // Miss at 0x1230, select 0010; also select 0000 -> way 0.
        quick_fill(32'h0000_1230, 4'b0010, 4'b0010, 4'd3);
        quick_fill(32'h0000_3000, 4'b0000, 4'b0001, 4'd0);

        // Stalled memory: response every third cycle, select 1010 -> way 1.
        lookup_valid = 1'b1; lookup_addr = 32'h0000_2050; hit_vector = 4'b0000; sel = 4'b1010;
        tick();
        hit_vector = 4'b0001;          // a hit presented while busy must be ignored
        resps = 0; beat = 0;
        for (int c = 0; c < 12; c++) begin
            mem_resp = (c % 3 == 2); mem_rdata = 32'h5000 + c;
            #1;
            check_eq("stall_mem_read", {63'd0, mem_read}, 64'd1);
            check_eq("stall_addr",     {32'd0, mem_address}, {32'd0, 32'h2050 + 32'(4*beat)});
            check_eq("stall_ww",       {60'd0, way_write}, mem_resp ? 64'h2 : 64'h0);
            check_eq("stall_no_upd",   {63'd0, upd}, 64'd0);
            if (mem_resp) begin resps++; beat++; end
            tick();
        end
        mem_resp = 1'b0; lookup_valid = 1'b0; hit_vector = '0;
        #1;
        check_eq("stall_resps",  64'(resps), 64'd4);
        check_eq("stall_done",   {63'd0, fill_done}, 64'd1);
        check_eq("stall_mru",    {60'd0, mru_vector}, 64'h2);
        check_eq("stall_index",  {60'd0, index}, 64'd5);
        tick();

        // Reset after two beats abandons the fill.
        lookup_valid = 1'b1; lookup_addr = 32'h0000_1230; hit_vector = '0; sel = 4'b0100;
        tick();
        lookup_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_resp = 1'b1; mem_rdata = 32'h77 + b;
            #1;
            check_eq("rmid_ww", {60'd0, way_write}, 64'h4);
            tick();
        end
        mem_resp = 1'b0;
        #2;
        check_eq("rmid_busy_pre", {63'd0, busy}, 64'd1);
        rst = 1'b1;                    // asserted away from any clock edge
        #1;
        check_eq("rmid_mem_read", {63'd0, mem_read}, 64'd0);
        check_eq("rmid_busy",     {63'd0, busy}, 64'd0);
        check_eq("rmid_addr",     {32'd0, mem_address}, 64'd0);
        tick();
        rst = 1'b0;
        mem_resp = 1'b1; mem_rdata = 32'hDEAD;
        #1;
        check_eq("post_rst_ww",  {60'd0, way_write}, 64'd0);
        check_eq("post_rst_tag", {63'd0, tag_write}, 64'd0);
        tick();
        mem_resp = 1'b0;
        #1;
        check_eq("post_rst_busy", {63'd0, busy}, 64'd0);
        check_eq("post_rst_upd",  {63'd0, upd}, 64'd0);
        lookup_valid = 1'b1; lookup_addr = 32'h0000_0040; hit_vector = 4'b1000;
        #1;
        check_eq("post_rst_hit", {63'd0, upd}, 64'd1);
        check_eq("post_rst_mru", {60'd0, mru_vector}, 64'h8);
        check_eq("post_rst_idx", {60'd0, index}, 64'd4);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_fill_ctrl.md
ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

Interface
REQ-001 SHALL have parameter num_sets, default 4, number of ways; every way vector is num_sets bits and one-hot.
REQ-002 SHALL have parameter lines_per_set, default 16, lines per way; IW = $clog2(lines_per_set).
REQ-003 SHALL have parameter words_per_line, default 4, 32-bit words per line; OW = $clog2(words_per_line).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-005 clk  input  1  sole clock; all state changes on posedge clk.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 lookup_valid  input  1  a cache access is presented this cycle.
REQ-008 lookup_addr  input  32  access byte address; index = bits [2+OW+IW-1 : 2+OW].
REQ-009 hit_vector  input  num_sets  tag-match per way for lookup_addr.
REQ-010 icache_replacement_select  input  num_sets  victim way from the replacement policy.
REQ-011 icache_replacement_update  output  1  write MRU state for index.
REQ-012 mru_vector  output  num_sets  way written as MRU.
REQ-013 index  output  IW  line index for the replacement policy.
REQ-014 mem_read  output  1  memory read request, held until mem_resp.
REQ-015 mem_address  output  32  word-aligned read address.
REQ-016 mem_resp  input  1  one-cycle read-data-valid strobe.
REQ-017 mem_rdata  input  32  read data, valid with mem_resp.
REQ-018 way_write  output  num_sets  one-hot data-array write enable.
REQ-019 way_index / way_offset / way_wdata  output  IW / OW / 32  data-array write location and data.
REQ-020 tag_write  output  1  tag/valid write into way_write at way_index, tag = latched lookup_addr[31:2+OW+IW].
REQ-021 busy  output  1  fill in progress; fill_done  output  1  one-cycle completion pulse.

Function
REQ-022 SHALL implement states IDLE, FETCH, UPDATE.
REQ-023 IDLE, lookup_valid=1, hit_vector!=0: icache_replacement_update=1, mru_vector=hit_vector, index=lookup index, same cycle (combinational).
REQ-024 IDLE, lookup_valid=1, hit_vector=0: latch lookup_addr line base, latch victim, beat counter=0, next state FETCH; no update this cycle.
REQ-025 Victim = lowest set bit of icache_replacement_select; all-zero select -> way 0; victim held constant for the whole fill.
REQ-026 FETCH: mem_read=1, mem_address = {latched line base, beat, 2'b00}, busy=1.
REQ-027 FETCH, mem_resp=1: way_write=victim, way_index=latched index, way_offset=beat, way_wdata=mem_rdata same cycle; beat increments.
REQ-028 FETCH, mem_resp on beat words_per_line-1: tag_write=1 same cycle, next state UPDATE; beat wraps to 0.
REQ-029 UPDATE (exactly one cycle): icache_replacement_update=1, mru_vector=victim, index=latched index, fill_done=1, busy=1; next IDLE.
REQ-030 Outside FETCH-with-mem_resp, way_write=0 and tag_write=0.
REQ-031 lookup_valid ignored in FETCH and UPDATE; no hit-driven update while busy.
REQ-032 mem_resp ignored in IDLE and UPDATE.
REQ-033 mem_read SHALL drop the cycle after the last mem_resp; no gap beats counted without mem_resp.
REQ-034 Miss-to-fill_done latency = 1 + (cycles until words_per_line responses) + 1.
REQ-035 icache_replacement_update=0 and mru_vector=0, index=0 whenever no update is asserted.

Reset
REQ-036 rst=1 SHALL immediately force state IDLE, beat=0, latched address/victim=0, all outputs 0 (mem_read, busy, fill_done, way_write, tag_write, icache_replacement_update included), independent of clk.
REQ-037 Reset mid-fill SHALL abandon the fill with no tag_write and no update; later mem_resp ignored.

Verification
REQ-038 Hit: lookup_valid=1, addr=0x0000_0040, hit_vector=0100 -> same cycle update=1, mru_vector=0100, index=4.
REQ-039 Miss: addr=0x0000_1230, select=0010, mem_resp each cycle -> mem_address 0x1230,0x1234,0x1238,0x123C; way_write=0010, way_index=3, offsets 0-3; tag_write on 4th beat; next cycle update=1, mru_vector=0010, fill_done=1.
REQ-040 Stalled memory: mem_resp every 3rd cycle -> mem_read held, beat advances only on mem_resp, 4 writes total.
REQ-041 Select=1010 -> victim 0010; select=0000 -> victim 0001; select change mid-fill -> victim unchanged.
REQ-042 rst asserted after 2 beats -> outputs 0 asynchronously, IDLE; subsequent mem_resp produces no way_write; lookup_valid hit after reset updates normally.
